core_sequencer: RTL
===================

Name: core_sequencer

Overview:
- Multi-cycle control FSM for the register-file/ALU datapath. Shares one memory port between instruction fetch and the datapath's load/store traffic.
- Sequences each instruction through fetch, decode, optional memory access and a single execute cycle.
- Drives the datapath's pc_inc and ld inputs and supplies ld_data.
- Sits between the datapath, the external instruction decoder and the memory.

Parameters:
- ACK_TIMEOUT, 255, maximum wait cycles for mem_ack in FETCH or MEM before faulting (1..255).
- TMO_W, 8, width of the wait counter; must satisfy ACK_TIMEOUT < 2**TMO_W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- run  input  1  level; 1 = keep issuing instructions
- pc  input  32  datapath program_counter
- dp_mem_addr  input  32  datapath mem_loca
- dp_st_data  input  32  datapath st_data
- dec_load  input  1  decoder: current instr is a load
- dec_store  input  1  decoder: current instr is a store
- mem_req  output  1  memory request, registered
- mem_we  output  1  1 = write, registered
- mem_addr  output  32  request address, registered
- mem_wdata  output  32  store data, registered
- mem_ack  input  1  memory completes request this cycle
- mem_rdata  input  32  read data, valid with mem_ack
- instr  output  32  instruction register
- instr_valid  output  1  instr holds a fetched instruction
- exec_en  output  1  one-cycle execute strobe; gates datapath register writes
- pc_inc  output  1  to datapath; asserted only in EXEC
- ld  output  1  to datapath; asserted in EXEC of a load
- ld_data  output  32  latched load data
- busy  output  1  state is not IDLE and not HALT
- err  output  1  sticky timeout fault

Behaviour:
- Reset, asynchronous: state=IDLE. mem_req, mem_we, exec_en, pc_inc, ld, instr_valid, err = 0. mem_addr, mem_wdata, instr, ld_data = 0. Wait counter = 0. mem_req drops immediately on reset assertion.
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
- IDLE: run=1 -> FETCH. On that edge: mem_req<=1, mem_we<=0, mem_addr<=pc.
- FETCH: hold req/addr/we stable until mem_ack=1.
  - On ack: instr<=mem_rdata, instr_valid<=1, mem_req<=0 -> DECODE.
  - Ack in the first FETCH cycle is legal.
- DECODE: exactly one cycle; dec_load/dec_store are sampled at its end.
  - Load: -> MEM with mem_req<=1, mem_we<=0, mem_addr<=dp_mem_addr.
  - Store: -> MEM with mem_req<=1, mem_we<=1, mem_addr<=dp_mem_addr, mem_wdata<=dp_st_data.
  - Neither: -> EXEC.
  - dec_load and dec_store both 1: treated as load (store ignored).
- MEM: hold the request stable until mem_ack.
  - On ack: mem_req<=0, mem_we<=0 -> EXEC.
  - If the access is a load, ld_data<=mem_rdata.
- EXEC: exactly one cycle with exec_en=1 and pc_inc=1; ld=1 iff the access was a load.
  - Exit: run=1 -> FETCH, issuing the next fetch with mem_addr<=pc+1, because the datapath increments its PC on this edge.
  - Exit: run=0 -> IDLE, with instr_valid<=0.
- exec_en, pc_inc and ld are registered; they are high only while state==EXEC.
- Latency with zero-wait memory: ALU instr 3 cycles (FETCH, DECODE, EXEC); load/store 4 cycles.
- Wait counter:
  - Cleared on entry to FETCH/MEM; increments each cycle without ack.
  - Reaching ACK_TIMEOUT without ack -> HALT: err<=1, mem_req<=0, instr_valid<=0.
  - Ack on the same cycle the count hits ACK_TIMEOUT counts as success.
- HALT: absorbing; exits only via rst_n. err stays 1. run is ignored.
- mem_ack while mem_req=0 is ignored.
- run deasserted mid-instruction: the current instruction completes through EXEC, then IDLE.
- ld_data and instr hold their values until overwritten.

Optional Feature:
- Macro CORE_SEQ_PERF_EN.
- When defined, adds two outputs, both cleared by reset and wrapping at 2**32:
  - retired_cnt, 32 bits: increments each EXEC cycle.
  - stall_cnt, 32 bits: increments each FETCH/MEM cycle with mem_ack=0.
- When undefined, both ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU instr, zero-wait ack, run=1, pc=0x10, dec_load=dec_store=0 -> mem_req high 1 cycle at addr 0x10; exec_en/pc_inc pulse on cycle 3; next fetch addr 0x11.
- Load, dp_mem_addr=0x200, mem_rdata=0xDEADBEEF with 2 wait cycles -> mem_we=0, addr 0x200 held stable 3 cycles; EXEC has ld=1, ld_data=0xDEADBEEF.
- Store, dp_st_data=0x12345678, dp_mem_addr=0x40 -> MEM cycle shows mem_we=1, mem_wdata=0x12345678; EXEC has ld=0.
- ACK_TIMEOUT=4, mem_ack tied low -> HALT after 4 FETCH cycles, err=1, mem_req=0, busy=0; run toggling ignored until rst_n pulse.
- run dropped during MEM -> instruction finishes with one EXEC pulse, then IDLE, busy=0, instr_valid=0; run=1 restarts fetch.
- rst_n asserted mid-FETCH with mem_req=1 -> mem_req drops without waiting for clk; all outputs at reset values; with CORE_SEQ_PERF_EN, both counters = 0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/memory/execute sequencer that shares one memory port with the datapath.
// Optional CORE_SEQ_PERF_EN adds retired-instruction and memory-stall counters.
module core_sequencer #(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter int unsigned TMO_W       = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [31:0] pc,
   input  logic [31:0] dp_mem_addr,
   input  logic [31:0] dp_st_data,
   input  logic        dec_load,
   input  logic        dec_store,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        exec_en,
   output logic        pc_inc,
   output logic        ld,
   output logic [31:0] ld_data,
   output logic        busy,
   output logic        err
`ifdef CORE_SEQ_PERF_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt
`endif
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_MEM    = 3'd3,
      ST_EXEC   = 3'd4,
      ST_HALT   = 3'd5
   } state_t;

   // Count value seen in the last permitted wait cycle; no ack there means timeout.
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

   state_t           state_r;
   logic [TMO_W-1:0] wait_cnt_r;
   logic             is_load_r;

   assign busy = (state_r != ST_IDLE) && (state_r != ST_HALT);

   // Sequencer state, memory request and datapath strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= '0;
         is_load_r   <= 1'b0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'h0000_0000;
         mem_wdata   <= 32'h0000_0000;
         instr       <= 32'h0000_0000;
         instr_valid <= 1'b0;
         exec_en     <= 1'b0;
         pc_inc      <= 1'b0;
         ld          <= 1'b0;
         ld_data     <= 32'h0000_0000;
         err         <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (run) begin
                  state_r    <= ST_FETCH;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= pc;
                  wait_cnt_r <= '0;
               end
            end
            ST_FETCH: begin
               if (mem_ack) begin
                  instr       <= mem_rdata;
                  instr_valid <= 1'b1;
                  mem_req     <= 1'b0;
                  state_r     <= ST_DECODE;
               end else if (wait_cnt_r == TMO_LAST) begin
                  state_r     <= ST_HALT;
                  err         <= 1'b1;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  instr_valid <= 1'b0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 1'b1;
               end
            end
            ST_DECODE: begin
               if (dec_load) begin
                  is_load_r  <= 1'b1;
                  state_r    <= ST_MEM;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= dp_mem_addr;
                  wait_cnt_r <= '0;
               end else if (dec_store) begin
                  is_load_r  <= 1'b0;
                  state_r    <= ST_MEM;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b1;
                  mem_addr   <= dp_mem_addr;
                  mem_wdata  <= dp_st_data;
                  wait_cnt_r <= '0;
               end else begin
                  is_load_r <= 1'b0;
                  state_r   <= ST_EXEC;
                  exec_en   <= 1'b1;
                  pc_inc    <= 1'b1;
                  ld        <= 1'b0;
               end
            end
            ST_MEM: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
                  if (is_load_r) begin
                     ld_data <= mem_rdata;
                  end
                  state_r <= ST_EXEC;
                  exec_en <= 1'b1;
                  pc_inc  <= 1'b1;
                  ld      <= is_load_r;
               end else if (wait_cnt_r == TMO_LAST) begin
                  state_r     <= ST_HALT;
                  err         <= 1'b1;
                  mem_req     <= 1'b0;
                  mem_we      <= 1'b0;
                  instr_valid <= 1'b0;
               end else begin
                  wait_cnt_r <= wait_cnt_r + 1'b1;
               end
            end
            ST_EXEC: begin
               exec_en <= 1'b0;
               pc_inc  <= 1'b0;
               ld      <= 1'b0;
               // The datapath bumps its PC on this same edge, so fetch from pc+1.
               if (run) begin
                  state_r    <= ST_FETCH;
                  mem_req    <= 1'b1;
                  mem_we     <= 1'b0;
                  mem_addr   <= pc + 32'd1;
                  wait_cnt_r <= '0;
               end else begin
                  state_r     <= ST_IDLE;
                  instr_valid <= 1'b0;
               end
            end
            ST_HALT: begin
               err     <= 1'b1;
               mem_req <= 1'b0;
               mem_we  <= 1'b0;
            end
            default: begin
               state_r     <= ST_HALT;
               err         <= 1'b1;
               mem_req     <= 1'b0;
               mem_we      <= 1'b0;
               instr_valid <= 1'b0;
               exec_en     <= 1'b0;
               pc_inc      <= 1'b0;
               ld          <= 1'b0;
            end
         endcase
      end
   end

`ifdef CORE_SEQ_PERF_EN
   // Retired-instruction and memory-stall counters, free-running with wrap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_cnt <= 32'h0000_0000;
         stall_cnt   <= 32'h0000_0000;
      end else begin
         if (state_r == ST_EXEC) begin
            retired_cnt <= retired_cnt + 32'd1;
         end
         if (((state_r == ST_FETCH) || (state_r == ST_MEM)) && !mem_ack) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
